// File: rtl/move_gen_ctrl_pkg.sv
// Shared types and helpers for the move-generation sequencer and its filter.
// Piece codes, FSM state encoding, pawn start ranks and square geometry.
package move_gen_ctrl_pkg;

  localparam logic [3:0] BROOK   = 4'd0;
  localparam logic [3:0] BKNIGHT = 4'd1;
  localparam logic [3:0] BBISHOP = 4'd2;
  localparam logic [3:0] BQUEEN  = 4'd3;
  localparam logic [3:0] BKING   = 4'd4;
  localparam logic [3:0] BPAWN   = 4'd5;
  localparam logic [3:0] WROOK   = 4'd6;
  localparam logic [3:0] WKNIGHT = 4'd7;
  localparam logic [3:0] WBISHOP = 4'd8;
  localparam logic [3:0] WQUEEN  = 4'd9;
  localparam logic [3:0] WKING   = 4'd10;
  localparam logic [3:0] WPAWN   = 4'd11;

  localparam logic [3:0] PIECE_INVALID_MIN = 4'd12;

  localparam logic [2:0] WPAWN_START_RANK = 3'd1;
  localparam logic [2:0] BPAWN_START_RANK = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StCapture,
    StResp
  } state_e;

  typedef enum logic [2:0] {
    KindRook,
    KindKnight,
    KindBishop,
    KindQueen,
    KindKing,
    KindPawn
  } piece_kind_e;

  function automatic logic is_white(logic [3:0] piece);
    return (piece >= WROOK) && (piece <= WPAWN);
  endfunction

  function automatic logic [2:0] file_of(logic [5:0] sq);
    return sq[2:0];
  endfunction

  function automatic logic [2:0] rank_of(logic [5:0] sq);
    return sq[5:3];
  endfunction

  function automatic logic [2:0] dist3(logic [2:0] a, logic [2:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic piece_kind_e kind_of(logic [3:0] piece);
    case (piece)
      BROOK,   WROOK:   return KindRook;
      BKNIGHT, WKNIGHT: return KindKnight;
      BBISHOP, WBISHOP: return KindBishop;
      BQUEEN,  WQUEEN:  return KindQueen;
      BKING,   WKING:   return KindKing;
      BPAWN,   WPAWN:   return KindPawn;
      default:          return KindRook;
    endcase
  endfunction

  // True when 'to' sits exactly one rank ahead of 'from' in the pawn's direction of travel.
  function automatic logic pawn_ahead(logic [5:0] from, logic [5:0] to, logic white);
    logic [3:0] rf;
    logic [3:0] rt;
    rf = {1'b0, rank_of(from)};
    rt = {1'b0, rank_of(to)};
    return white ? (rt == rf + 4'd1) : (rt + 4'd1 == rf);
  endfunction

endpackage

// File: rtl/move_gen_ctrl_if.sv
// Request/response handshake and square-array drive signals of the sequencer.
// 'slave' is the controller's view, 'master' the host/array side.
interface move_gen_ctrl_if;

  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_square;
  logic [3:0]  req_piece;
  logic [63:0] req_occ;
  logic [63:0] req_white;

  logic        board_init;
  logic [5:0]  square_calc;
  logic [3:0]  piece_type_calc;
  logic [63:0] board_occ;
  logic [63:0] board_white;
  logic [63:0] movebits;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_mask;
  logic [6:0]  resp_count;
  logic        resp_err;

  modport slave (
    input  req_valid, req_square, req_piece, req_occ, req_white, movebits, resp_ready,
    output req_ready, board_init, square_calc, piece_type_calc, board_occ, board_white,
    output resp_valid, resp_mask, resp_count, resp_err
  );

  modport master (
    output req_valid, req_square, req_piece, req_occ, req_white, movebits, resp_ready,
    input  req_ready, board_init, square_calc, piece_type_calc, board_occ, board_white,
    input  resp_valid, resp_mask, resp_count, resp_err
  );

endinterface

// File: rtl/move_gen_ctrl_move_filter.sv
// Combinational legality filter applied to the raw array movebits: own-colour clear,
// knight/king geometry limits, pawn push/capture/double-push rules, and popcount.
module move_gen_ctrl_move_filter
  import move_gen_ctrl_pkg::*;
(
  input  logic [5:0]  sq_i,
  input  logic [3:0]  piece_i,
  input  logic [63:0] occ_i,
  input  logic [63:0] white_i,
  input  logic [63:0] raw_i,
  output logic [63:0] mask_o,
  output logic [6:0]  count_o
);

  piece_kind_e kind;
  logic        side_white;
  logic [2:0]  src_file;
  logic [2:0]  src_rank;
  logic [63:0] base;
  logic [5:0]  push1_sq;
  logic [5:0]  push2_sq;
  logic        dbl_ok;

  assign kind       = kind_of(piece_i);
  assign side_white = is_white(piece_i);
  assign src_file   = file_of(sq_i);
  assign src_rank   = rank_of(sq_i);
  assign base       = raw_i & ~(occ_i & (side_white ? white_i : ~white_i));

  // Wrapped arithmetic is harmless: these squares are only read from a start rank.
  assign push1_sq = side_white ? (sq_i + 6'd8)  : (sq_i - 6'd8);
  assign push2_sq = side_white ? (sq_i + 6'd16) : (sq_i - 6'd16);
  assign dbl_ok   = (kind == KindPawn) &&
                    (src_rank == (side_white ? WPAWN_START_RANK : BPAWN_START_RANK)) &&
                    !occ_i[push1_sq] && !occ_i[push2_sq];

  always_comb begin
    mask_o = '0;
    for (int i = 0; i < 64; i++) begin
      case (kind)
        KindKnight: begin
          mask_o[i] = base[i] && ((dist3(file_of(6'(i)), src_file) == 3'd1) ||
                                  (dist3(file_of(6'(i)), src_file) == 3'd2));
        end
        KindKing: begin
          mask_o[i] = base[i] && (dist3(file_of(6'(i)), src_file) <= 3'd1) &&
                                 (dist3(rank_of(6'(i)), src_rank) <= 3'd1);
        end
        KindPawn: begin
          // base already excludes own pieces, so an occupied target is an enemy.
          mask_o[i] = base[i] && pawn_ahead(sq_i, 6'(i), side_white) &&
                      (((dist3(file_of(6'(i)), src_file) == 3'd0) && !occ_i[i]) ||
                       ((dist3(file_of(6'(i)), src_file) == 3'd1) && occ_i[i]));
        end
        default: mask_o[i] = base[i];
      endcase
    end
    if (dbl_ok) begin
      mask_o[push2_sq] = 1'b1;
    end
    mask_o[sq_i] = 1'b0;
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < 64; i++) begin
      count_o = count_o + {6'd0, mask_o[i]};
    end
  end

endmodule

// File: rtl/move_gen_ctrl.sv
// Sequencer for the 64-square propagation array: load, settle, capture, filter,
// then return the legal-move mask and count over a valid/ready handshake.
module move_gen_ctrl
  import move_gen_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  move_gen_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  sq_q, sq_d;
  logic [3:0]  piece_q, piece_d;
  logic [63:0] occ_q, occ_d;
  logic [63:0] white_q, white_d;
  logic        board_init_q, board_init_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_mask_q, resp_mask_d;
  logic [6:0]  resp_count_q, resp_count_d;
  logic        resp_err_q, resp_err_d;

  logic        accept;
  logic        piece_bad;
  logic [63:0] filt_mask;
  logic [6:0]  filt_count;

  assign accept    = (state_q == StIdle) && bus.req_valid;
  assign piece_bad = bus.req_piece >= PIECE_INVALID_MIN;

  move_gen_ctrl_move_filter u_filter (
    .sq_i    (sq_q),
    .piece_i (piece_q),
    .occ_i   (occ_q),
    .white_i (white_q),
    .raw_i   (bus.movebits),
    .mask_o  (filt_mask),
    .count_o (filt_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = piece_bad ? StResp : StLoad;
      StLoad:    state_d = StSettle;
      StSettle:  if (cnt_q == 4'd0) state_d = StCapture;
      StCapture: state_d = StResp;
      StResp:    if (bus.resp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_comb begin
    board_init_d = (state_d == StLoad);
    resp_valid_d = (state_d == StResp);
    bus.req_ready = (state_q == StIdle);
  end

  always_comb begin
    cnt_d        = cnt_q;
    sq_d         = sq_q;
    piece_d      = piece_q;
    occ_d        = occ_q;
    white_d      = white_q;
    resp_mask_d  = resp_mask_q;
    resp_count_d = resp_count_q;
    resp_err_d   = resp_err_q;

    if (state_q == StLoad) begin
      cnt_d = 4'(SETTLE_CYCLES - 1);
    end else if (state_q == StSettle) begin
      cnt_d = cnt_q - 4'd1;
    end

    // Invalid pieces never reach the array, so its drive registers keep their old values.
    if (accept && !piece_bad) begin
      sq_d    = bus.req_square;
      piece_d = bus.req_piece;
      occ_d   = bus.req_occ;
      white_d = bus.req_white;
    end

    if (accept && piece_bad) begin
      resp_mask_d  = '0;
      resp_count_d = '0;
      resp_err_d   = 1'b1;
    end else if (state_q == StCapture) begin
      resp_mask_d  = filt_mask;
      resp_count_d = filt_count;
      resp_err_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      sq_q         <= '0;
      piece_q      <= '0;
      occ_q        <= '0;
      white_q      <= '0;
      board_init_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_mask_q  <= '0;
      resp_count_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sq_q         <= sq_d;
      piece_q      <= piece_d;
      occ_q        <= occ_d;
      white_q      <= white_d;
      board_init_q <= board_init_d;
      resp_valid_q <= resp_valid_d;
      resp_mask_q  <= resp_mask_d;
      resp_count_q <= resp_count_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.board_init      = board_init_q;
  assign bus.square_calc     = sq_q;
  assign bus.piece_type_calc = piece_q;
  assign bus.board_occ       = occ_q;
  assign bus.board_white     = white_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_mask       = resp_mask_q;
  assign bus.resp_count      = resp_count_q;
  assign bus.resp_err        = resp_err_q;

endmodule

// File: tb/tb_move_gen_ctrl.sv
// Scoreboard bench for move_gen_ctrl: directed scenarios plus randomized requests checked
// against a square-arithmetic reference model of the piece rules.
module tb_move_gen_ctrl;

  localparam int unsigned S = 2;

  typedef struct packed {
    logic [63:0] mask;
    logic [6:0]  count;
    logic        err;
  } resp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  resp_t sb[$];
  resp_t mon_exp;

  move_gen_ctrl_if bus ();

  move_gen_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference model: walks target squares with integer rank/file arithmetic.
  function automatic resp_t ref_resp(input int sq, input int pc, input logic [63:0] occ,
                                     input logic [63:0] wh, input logic [63:0] raw);
    resp_t r;
    logic [63:0] m;
    int f, rk, kind, dir, t, start;
    bit w, keep;
    m = '0;
    if (pc >= 12) begin
      r.mask = '0; r.count = '0; r.err = 1'b1;
      return r;
    end
    f = sq % 8; rk = sq / 8; w = (pc >= 6); kind = pc % 6;
    if (kind == 5) begin
      dir = w ? 8 : -8;
      t = sq + dir;
      if (t >= 0 && t < 64 && raw[t] && !occ[t]) m[t] = 1'b1;
      for (int d = -1; d <= 1; d += 2) begin
        t = sq + dir + d;
        if (t >= 0 && t < 64 && iabs(t % 8 - f) == 1 && raw[t] && occ[t] && (wh[t] != w))
          m[t] = 1'b1;
      end
      start = w ? 1 : 6;
      if (rk == start && !occ[sq + dir] && !occ[sq + 2 * dir]) m[sq + 2 * dir] = 1'b1;
    end else begin
      for (int t2 = 0; t2 < 64; t2++) begin
        if (raw[t2] && !(occ[t2] && (wh[t2] == w))) begin
          if (kind == 1) keep = (iabs(t2 % 8 - f) == 1) || (iabs(t2 % 8 - f) == 2);
          else if (kind == 4) keep = (iabs(t2 / 8 - rk) <= 1) && (iabs(t2 % 8 - f) <= 1);
          else keep = 1'b1;
          if (keep) m[t2] = 1'b1;
        end
      end
    end
    m[sq] = 1'b0;
    r.mask = m; r.count = 7'($countones(m)); r.err = 1'b0;
    return r;
  endfunction

  // Monitor: a handshake completes at the next rising edge when both are high here.
  always @(negedge clock) begin
    if (reset_n && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_resp: got mask %h, expected no response", bus.resp_mask);
      end else begin
        mon_exp = sb.pop_front();
        check("resp_mask", bus.resp_mask, mon_exp.mask);
        check("resp_count", 64'(bus.resp_count), 64'(mon_exp.count));
        check("resp_err", 64'(bus.resp_err), 64'(mon_exp.err));
      end
    end
  end

  // Issues one request from posedge+1 and follows it to the handshake.
  task automatic do_req(input logic [5:0] sq, input logic [3:0] pc, input logic [63:0] occ,
                        input logic [63:0] wh, input logic [63:0] raw, input int hold,
                        input bit pre_ready, output resp_t got);
    int k, first, inits;
    bit valid_pc;
    got = '0;
    valid_pc = (pc < 4'd12);
    k = 0;
    while (!bus.req_ready && k < 50) begin @(posedge clock); #1; k++; end
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    sb.push_back(ref_resp(int'(sq), int'(pc), occ, wh, raw));
    bus.req_square = sq; bus.req_piece = pc; bus.req_occ = occ; bus.req_white = wh;
    bus.movebits = raw; bus.resp_ready = pre_ready; bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    first = 0; inits = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.board_init) inits++;
      if (c == 1) begin
        check("init_at_load", 64'(bus.board_init), 64'(valid_pc));
        if (valid_pc) begin
          check("square_calc", 64'(bus.square_calc), 64'(sq));
          check("piece_type_calc", 64'(bus.piece_type_calc), 64'(pc));
          check("board_occ", bus.board_occ, occ);
          check("board_white", bus.board_white, wh);
        end
      end
      if (bus.resp_valid) begin first = c; break; end
      @(posedge clock); #1;
    end
    check("init_pulses", 64'(inits), 64'(valid_pc ? 1 : 0));
    check("latency", 64'(first), 64'(valid_pc ? 3 + S : 1));
    if (first == 0) begin
      sb.delete();
      return;
    end
    got.mask = bus.resp_mask; got.count = bus.resp_count; got.err = bus.resp_err;
    if (hold > 0) begin
      bus.resp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(posedge clock); #1;
        check("bp_valid", 64'(bus.resp_valid), 64'd1);
        check("bp_req_ready", 64'(bus.req_ready), 64'd0);
        check("bp_mask", bus.resp_mask, got.mask);
        check("bp_count", 64'(bus.resp_count), 64'(got.count));
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    check("post_hs_valid", 64'(bus.resp_valid), 64'd0);
    check("post_hs_ready", 64'(bus.req_ready), 64'd1);
    bus.resp_ready = $urandom_range(0, 1) == 1;
  endtask

  initial begin
    resp_t got;
    logic [63:0] occ, wh, raw;
    logic [5:0] sq;
    logic [3:0] pc;
    int seen_init;

    bus.req_valid = 1'b0; bus.req_square = '0; bus.req_piece = '0;
    bus.req_occ = '0; bus.req_white = '0; bus.movebits = '0; bus.resp_ready = 1'b0;

    #3 reset_n = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    check("rst_board_init", 64'(bus.board_init), 64'd0);
    check("rst_square_calc", 64'(bus.square_calc), 64'd0);
    check("rst_piece_calc", 64'(bus.piece_type_calc), 64'd0);
    check("rst_board_occ", bus.board_occ, 64'd0);
    check("rst_board_white", bus.board_white, 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_mask", bus.resp_mask, 64'd0);
    check("rst_resp_count", 64'(bus.resp_count), 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    seen_init = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.board_init) seen_init++;
      @(posedge clock); #1;
    end
    check("idle_no_init", 64'(seen_init), 64'd0);

    // White pawn, empty board
    do_req(6'd12, 4'd11, 64'd1 << 12, 64'd1 << 12, (64'd1 << 19) | (64'd1 << 20) | (64'd1 << 21),
           0, 1'b0, got);
    check("wp_empty_mask", got.mask, (64'd1 << 20) | (64'd1 << 28));
    check("wp_empty_count", 64'(got.count), 64'd2);
    check("wp_empty_err", 64'(got.err), 64'd0);

    // White pawn capture, blocked double push
    do_req(6'd12, 4'd11, (64'd1 << 12) | (64'd1 << 21) | (64'd1 << 28), 64'd1 << 12,
           (64'd1 << 19) | (64'd1 << 20) | (64'd1 << 21), 0, 1'b0, got);
    check("wp_cap_mask", got.mask, (64'd1 << 20) | (64'd1 << 21));
    check("wp_cap_count", 64'(got.count), 64'd2);

    // White king on a corner with wrap-around bits from the stub
    do_req(6'd0, 4'd10, 64'd1, 64'd1,
           (64'd1 << 1) | (64'd1 << 2) | (64'd1 << 8) | (64'd1 << 9) | (64'd1 << 63),
           0, 1'b1, got);
    check("wk_mask", got.mask, (64'd1 << 1) | (64'd1 << 8) | (64'd1 << 9));
    check("wk_count", 64'(got.count), 64'd3);

    // Invalid piece code, with backpressure
    do_req(6'd30, 4'd13, 64'hFFFF, 64'hFF, '1, 5, 1'b0, got);
    check("inv_mask", got.mask, 64'd0);
    check("inv_count", 64'(got.count), 64'd0);
    check("inv_err", 64'(got.err), 64'd1);

    // Backpressure on a valid piece
    do_req(6'd27, 4'd9, 64'd1 << 27, 64'd1 << 27, 64'h00FF_0000_0000_FF00, 5, 1'b0, got);

    // Abort during SETTLE: no response may appear
    bus.resp_ready = 1'b1;
    bus.req_square = 6'd12; bus.req_piece = 4'd11; bus.req_occ = 64'd1 << 12;
    bus.req_white = 64'd1 << 12; bus.movebits = 64'd1 << 20; bus.req_valid = 1'b1;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    check("abort_load_init", 64'(bus.board_init), 64'd1);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("abort_init", 64'(bus.board_init), 64'd0);
    check("abort_valid", 64'(bus.resp_valid), 64'd0);
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
    do_req(6'd52, 4'd5, (64'd1 << 52) | (64'd1 << 43), 64'd1 << 43,
           (64'd1 << 43) | (64'd1 << 44) | (64'd1 << 45), 0, 1'b1, got);
    check("bp_after_abort_mask", got.mask, (64'd1 << 43) | (64'd1 << 44) | (64'd1 << 36));

    // Randomized requests
    for (int n = 0; n < 80; n++) begin
      pc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      sq = 6'($urandom_range(0, 63));
      if ((pc % 6 == 5) && $urandom_range(0, 1) == 1)
        sq = {(pc >= 4'd6) ? 3'd1 : 3'd6, 3'($urandom_range(0, 7))};
      occ = {$urandom(), $urandom()} & {$urandom(), $urandom()};
      wh = {$urandom(), $urandom()};
      raw = {$urandom(), $urandom()};
      occ[sq] = 1'b1;
      wh[sq] = (pc >= 4'd6);
      do_req(sq, pc, occ, wh, raw, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
    end

    repeat (4) @(posedge clock);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/move_gen_ctrl.md
Name: move_gen_ctrl

Overview:
- Sequencer for the 64-square move-propagation array.
- Accepts a move-generation request (source square, piece type) and a board snapshot. Pulses the array's init to load occupancy and colour, waits a programmable settle time for the combinational propagation to ripple, then captures the 64 movebits.
- Applies the piece rules the array cannot express on its own: the king one-step limit, pawn forward/capture legality, and the pawn double push.
- Returns the legal-move mask and a move count through a valid/ready handshake. It sits between the software-facing register interface and the square array in the top level.

Parameters:
- SETTLE_CYCLES, 2, cycles the array is left to propagate after init drops (legal range 1..15).

Ports:
- clock  in  1  system clock (one clock domain)
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_square  in  6  source square, index = rank*8+file; rank 0 is white's back rank
- req_piece  in  4  piece code: BROOK=0 … BPAWN=5, WROOK=6 … WPAWN=11
- req_occ  in  64  occupancy snapshot, 1 = occupied
- req_white  in  64  colour snapshot, 1 = white piece (only meaningful where occupied)
- board_init  out  1  init strobe to every square
- square_calc  out  6  source square driven to the array
- piece_type_calc  out  4  piece type driven to the array
- board_occ  out  64  per-square occupied input to the array
- board_white  out  64  per-square colour input to the array
- movebits  in  64  per-square movebit outputs from the array
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_mask  out  64  legal destination squares
- resp_count  out  7  popcount of resp_mask (0..64)
- resp_err  out  1  request piece code was invalid (12..15)

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - All registered outputs are 0: board_init, square_calc, piece_type_calc, board_occ, board_white, resp_*.
  - req_ready=1 after reset is released.
- States: IDLE, LOAD, SETTLE, CAPTURE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready (cycle T), register square, piece, occ and white.
  - If the piece code is ≥12, go to RESP with mask=0, count=0, err=1; the array is never touched.
  - Otherwise go to LOAD.
- LOAD (T+1):
  - board_init=1 for exactly one cycle.
  - square_calc, piece_type_calc, board_occ and board_white are driven from the registers.
  - These stay stable from LOAD through CAPTURE.
- SETTLE:
  - board_init=0 for SETTLE_CYCLES cycles, counted by a 4-bit down-counter.
  - Then go to CAPTURE.
- CAPTURE (single cycle):
  - Sample movebits.
  - Filter: raw&~own_colour_occupied, then the piece rules below.
  - Register the mask and its popcount. Go to RESP.
- RESP:
  - resp_valid=1; resp_mask, resp_count and resp_err are held stable until resp_valid&&resp_ready.
  - req_ready=0 throughout.
  - On handshake, go to IDLE and clear resp_valid.
  - No request overlap: back-to-back requests cost one IDLE cycle minimum.
- Latency: first resp_valid at T+3+SETTLE_CYCLES for a valid piece; at T+1 for an invalid piece.
- Piece rules applied in CAPTURE (file = sq%8, rank = sq/8):
  - Rook, bishop, queen, knight: raw mask after the own-colour clear. The knight additionally keeps only bits whose file differs by 1 or 2, which suppresses wrap-around.
  - King (4/10): keep only bits with |Δrank|≤1 and |Δfile|≤1.
  - WPAWN, forward move: sq+8 is kept only if it is empty.
  - WPAWN, captures: sq+7 and sq+9 are kept only if occupied by black and the file differs by exactly 1. All other bits are cleared.
  - WPAWN, double push: if rank==1 and sq+8 and sq+16 are both empty, set sq+16.
  - BPAWN: mirror of WPAWN with sq-8, sq-7/sq-9 (capturing white), and a double push from rank 6 to sq-16.
  - Any bit equal to the source square is cleared.
- Out-of-range index arithmetic (e.g. sq+16>63) produces no bit.
- reset_n asserted in any state aborts to IDLE asynchronously. No response is produced for an aborted request, and board_init drops immediately.
- resp_ready held high while resp_valid=0 has no effect.

Decomposition:
- chess_pkg holds:
  - piece codes 0..11 and PIECE_INVALID_MIN=12
  - the state enum
  - WPAWN_START_RANK=1 and BPAWN_START_RANK=6
  - helper functions is_white(piece) and file_of/rank_of(sq)
- One sub-module, move_filter: purely combinational. It takes the registered square, piece, occ, white and the raw movebits, and produces the filtered 64-bit mask and 7-bit count. The controller FSM instantiates it and registers its outputs in CAPTURE.

Test Plan:
- Reset / idle: hold reset_n=0, release → all outputs 0 and req_ready=1; req_valid=0 for 10 cycles → board_init never asserts.
- White pawn, empty board: req_square=12, req_piece=11, occ=1<<12, array stub returns bits {19,20,21}, SETTLE_CYCLES=2 → board_init high only at T+1; resp_valid at T+5; mask={20,28}; count=2; err=0.
- White pawn capture: as above but occ has bit 21 set with white bit 21=0, and bit 28 occupied → mask={20,21} (no double push); count=2.
- White king wrap filter: req_square=0, req_piece=10, stub returns {1,2,8,9,63} → mask={1,8,9}; count=3.
- Invalid piece: req_piece=13 → resp_valid at T+1 with mask=0, count=0, err=1; board_init stays 0.
- Backpressure and abort:
  - Hold resp_ready=0 for 5 cycles → resp_* stable and req_ready=0; resp_ready=1 → IDLE next cycle.
  - Separately, pulse reset_n low during SETTLE → board_init=0 and resp_valid=0 immediately; the next request completes normally.
